// File: rtl/ctrl_pipeline_pkg.sv
// ctrl_pipeline_pkg: control bundle types, opcode constants and branch decode helper.
package ctrl_pipeline_pkg;
  typedef enum logic [2:0] {
    BR_NONE = 3'd0, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
  } branch_op_e;
  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC4 = 2'b10, WB_IMM = 2'b11} wb_sel_e;
  typedef struct packed {
    logic       reg_wr_en;
    logic       alu_src;
    logic       alu_a_pc;
    logic       mem_wr_en;
    logic       mem_rd_en;
    branch_op_e branch_op;
    wb_sel_e    wb_sel;
  } ctrl_t;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  // funct3 010/011 have no branch meaning and map to BR_NONE
  function automatic branch_op_e br_op(input logic [2:0] f3);
    return f3 == 3'b000 ? BR_EQ  : f3 == 3'b001 ? BR_NE  :
           f3 == 3'b100 ? BR_LT  : f3 == 3'b101 ? BR_GE  :
           f3 == 3'b110 ? BR_LTU : f3 == 3'b111 ? BR_GEU : BR_NONE;
  endfunction
endpackage

// File: rtl/ctrl_pipeline_if.sv
// ctrl_pipeline_if: ID-side inputs and per-stage control outputs of the control pipeline.
interface ctrl_pipeline_if #(parameter int REG_AW = 5);
  import ctrl_pipeline_pkg::*;
  logic              id_valid;
  logic [31:0]       id_instr;
  logic              ex_redirect;
  logic              mem_stall;
  logic              id_stall;
  logic              id_illegal;
  logic              ex_valid, mem_valid, wb_valid;
  ctrl_t             ex_ctrl, mem_ctrl, wb_ctrl;
  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
  modport master (
    output id_valid, id_instr, ex_redirect, mem_stall,
    input  id_stall, id_illegal, ex_valid, mem_valid, wb_valid,
    input  ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd
  );
  modport slave (
    input  id_valid, id_instr, ex_redirect, mem_stall,
    output id_stall, id_illegal, ex_valid, mem_valid, wb_valid,
    output ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd
  );
endinterface

// File: rtl/ctrl_pipeline_decode.sv
// ctrl_decode: combinational RV32I decode into a control bundle, source-use flags and rd.
module ctrl_decode import ctrl_pipeline_pkg::*; #(
  parameter int REG_AW     = 5,
  parameter bit EN_UPPER   = 1,
  parameter bit EN_FULL_BR = 1
) (
  input  logic [31:0]       instr_i,
  output ctrl_t             ctrl_o,
  output logic              rs1_use_o,
  output logic              rs2_use_o,
  output logic [REG_AW-1:0] rs1_o,
  output logic [REG_AW-1:0] rs2_o,
  output logic [REG_AW-1:0] rd_o,
  output logic              illegal_o
);
  logic [6:0] opcode;
  logic [2:0] f3;
  ctrl_t      c;
  logic       u1, u2, ill;
  logic [6:0] unused_funct7;
  assign opcode        = instr_i[6:0];
  assign f3            = instr_i[14:12];
  assign unused_funct7 = instr_i[31:25];
  assign rs1_o         = REG_AW'(instr_i[19:15]);
  assign rs2_o         = REG_AW'(instr_i[24:20]);
  always_comb begin
    c   = '0;
    u1  = 1'b0;
    u2  = 1'b0;
    ill = 1'b0;
    case (opcode)
      OP_R:      begin c.reg_wr_en = 1'b1; u1 = 1'b1; u2 = 1'b1; end
      OP_I:      begin c.reg_wr_en = 1'b1; c.alu_src = 1'b1; u1 = 1'b1; end
      OP_LOAD:   begin c.reg_wr_en = 1'b1; c.alu_src = 1'b1; c.mem_rd_en = 1'b1; c.wb_sel = WB_MEM; u1 = 1'b1; end
      OP_STORE:  begin c.mem_wr_en = 1'b1; c.alu_src = 1'b1; u1 = 1'b1; u2 = 1'b1; end
      OP_BRANCH: begin
        c.branch_op = br_op(f3);
        u1  = 1'b1;
        u2  = 1'b1;
        ill = (br_op(f3) == BR_NONE) || (!EN_FULL_BR && f3[2]);
      end
      OP_JAL:    begin c.reg_wr_en = 1'b1; c.wb_sel = WB_PC4; end
      OP_JALR:   begin c.reg_wr_en = 1'b1; c.wb_sel = WB_PC4; c.alu_src = 1'b1; u1 = 1'b1; end
      OP_LUI:    begin c.reg_wr_en = 1'b1; c.wb_sel = WB_IMM; ill = !EN_UPPER; end
      OP_AUIPC:  begin c.reg_wr_en = 1'b1; c.alu_src = 1'b1; c.alu_a_pc = 1'b1; ill = !EN_UPPER; end
      default:   ill = 1'b1;
    endcase
  end
  assign rd_o      = ill ? '0 : REG_AW'(instr_i[11:7]);
  assign rs1_use_o = u1 & ~ill;
  assign rs2_use_o = u2 & ~ill;
  assign illegal_o = ill;
  // writes to x0 are dropped here so later stages never need to re-check rd
  always_comb begin
    ctrl_o = ill ? '0 : c;
    ctrl_o.reg_wr_en = ctrl_o.reg_wr_en & (rd_o != '0);
  end
endmodule

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: ID decode plus registered EX/MEM/WB control stages with load-use,
// redirect-flush and memory-stall handling.
module ctrl_pipeline import ctrl_pipeline_pkg::*; #(
  parameter int REG_AW     = 5,
  parameter bit EN_UPPER   = 1,
  parameter bit EN_FULL_BR = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  ctrl_pipeline_if.slave bus
);
  ctrl_t             id_ctrl, ex_ctrl_d, ex_ctrl_q, mem_ctrl_q, wb_ctrl_q;
  logic              rs1_use, rs2_use, illegal, load_use;
  logic              ex_valid_d, ex_valid_q, mem_valid_q, wb_valid_q;
  logic [REG_AW-1:0] rs1, rs2, id_rd, ex_rd_d, ex_rd_q, mem_rd_q, wb_rd_q;
  ctrl_decode #(.REG_AW(REG_AW), .EN_UPPER(EN_UPPER), .EN_FULL_BR(EN_FULL_BR)) u_decode (
    .instr_i   (bus.id_instr),
    .ctrl_o    (id_ctrl),
    .rs1_use_o (rs1_use),
    .rs2_use_o (rs2_use),
    .rs1_o     (rs1),
    .rs2_o     (rs2),
    .rd_o      (id_rd),
    .illegal_o (illegal)
  );
  assign load_use = bus.id_valid & ex_valid_q & ex_ctrl_q.mem_rd_en & (ex_rd_q != '0) &
                    ((rs1_use & (rs1 == ex_rd_q)) | (rs2_use & (rs2 == ex_rd_q)));
  // a redirect squashes the ID instruction, so a load-use stall would be pointless
  assign bus.id_stall   = bus.mem_stall | (load_use & ~bus.ex_redirect);
  assign bus.id_illegal = bus.id_valid & illegal;
  assign ex_valid_d = bus.id_valid & ~illegal & ~bus.ex_redirect & ~load_use;
  assign ex_ctrl_d  = ex_valid_d ? id_ctrl : '0;
  assign ex_rd_d    = ex_valid_d ? id_rd : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
      ex_ctrl_q   <= '0;
      mem_ctrl_q  <= '0;
      wb_ctrl_q   <= '0;
      ex_rd_q     <= '0;
      mem_rd_q    <= '0;
      wb_rd_q     <= '0;
    end else if (!bus.mem_stall) begin
      ex_valid_q  <= ex_valid_d;
      mem_valid_q <= ex_valid_q;
      wb_valid_q  <= mem_valid_q;
      ex_ctrl_q   <= ex_ctrl_d;
      mem_ctrl_q  <= ex_ctrl_q;
      wb_ctrl_q   <= mem_ctrl_q;
      ex_rd_q     <= ex_rd_d;
      mem_rd_q    <= ex_rd_q;
      wb_rd_q     <= mem_rd_q;
    end
  end
  assign bus.ex_valid  = ex_valid_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.ex_ctrl   = ex_ctrl_q;
  assign bus.mem_ctrl  = mem_ctrl_q;
  assign bus.wb_ctrl   = wb_ctrl_q;
  assign bus.ex_rd     = ex_rd_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.wb_rd     = wb_rd_q;
endmodule

// File: doc/ctrl_pipeline.md
# ctrl_pipeline

Parametrised successor to the single-cycle control decoder: decodes a full 32-bit RV32I instruction in ID, then carries the control bundle through registered ID/EX, EX/MEM and MEM/WB stages. Detects load-use hazards, handles branch-redirect flushes and memory-stall freezes. Sits between the instruction fetch register and the datapath stage muxes of the pipelined core.

## Interface
- `REG_AW`, 5: register-index width.
- `EN_UPPER`, 1: decode LUI/AUIPC; when 0 they are illegal.
- `EN_FULL_BR`, 1: decode BLT/BGE/BLTU/BGEU; when 0 only BEQ/BNE are legal.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `id_valid` in 1: `id_instr` holds a real instruction.
- `id_instr` in 32: instruction in ID.
- `ex_redirect` in 1: EX resolved a taken branch or jump; squash the younger instruction.
- `mem_stall` in 1: data memory busy; freeze all stages.
- `id_stall` out 1: hold IF/ID this cycle (load-use or `mem_stall`).
- `id_illegal` out 1: `id_valid` and opcode/funct3 not decodable.
- `ex_valid`, `mem_valid`, `wb_valid` out 1 each: stage holds a live instruction.
- `ex_ctrl`, `mem_ctrl`, `wb_ctrl` out `ctrl_t`: registered control bundle per stage.
- `ex_rd`, `mem_rd`, `wb_rd` out `REG_AW`: destination index per stage.

## Operation
- `ctrl_t` fields:
  - `reg_wr_en`, `alu_src`, `alu_a_pc`, `mem_wr_en`, `mem_rd_en`, `branch_op[2:0]`, `wb_sel[1:0]`.
  - `wb_sel` encoding: 00 ALU, 01 MEM, 10 PC+4, 11 IMM.
- Decode per opcode:
  - R: `reg_wr_en`.
  - I-ALU: `reg_wr_en`, `alu_src`.
  - LOAD: adds `mem_rd_en`, `wb_sel`=01.
  - STORE: `mem_wr_en`, `alu_src`.
  - JAL: `reg_wr_en`, `wb_sel`=10.
  - JALR: JAL plus `alu_src`.
  - LUI: `reg_wr_en`, `wb_sel`=11.
  - AUIPC: `reg_wr_en`, `alu_src`, `alu_a_pc`.
- Branch funct3: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. Funct3 010/011 are illegal.
- Illegal instructions decode to an all-zero bundle, assert `id_illegal`, and enter EX as a bubble.
- Source usage:
  - rs1 used by R, I-ALU, LOAD, STORE, BRANCH, JALR.
  - rs2 used by R, STORE, BRANCH.
- Load-use hazard: `ex_valid` and `ex_ctrl.mem_rd_en` and `ex_rd`≠0 and (`ex_rd`==rs1 used or `ex_rd`==rs2 used) and `id_valid`.
- Stage update priority, highest first:
  1. Reset: all valids and bundles cleared.
  2. `mem_stall`: every stage register holds; `id_stall`=1.
  3. `ex_redirect`: EX loads a bubble; ID instruction discarded; MEM/WB advance normally.
  4. Load-use: EX loads a bubble; `id_stall`=1; MEM/WB advance.
  5. Normal: ID→EX, EX→MEM, MEM→WB.
- A bubble has valid=0, bundle=0, rd=0. Stage outputs carry their bundle unconditionally; consumers gate with the valid.
- `reg_wr_en` is forced 0 in the bundle when rd=0.

## Timing
- Reset values: every output 0.
- Decode is combinational in ID. The bundle appears on `ex_*` one cycle after acceptance, on `mem_*` after two, and on `wb_*` after three (absent stalls).
- `id_stall` and `id_illegal` are combinational from the current inputs and EX state.
- Load-use stall lasts exactly one cycle; the following cycle the load is in MEM and ID proceeds.
- `ex_redirect` together with a load-use condition: the redirect wins, and `id_stall` stays 0.
- `mem_stall` together with `ex_redirect`: freeze wins. The redirect must be held by its source until `mem_stall` drops.
- Reset asserted mid-pipeline clears all three stages at the next edge.

## Structure
- Shared package holds:
  - `ctrl_t` typedef.
  - `branch_op_e` enum: NONE=0, EQ, NE, LT, GE, LTU, GEU.
  - `wb_sel_e` enum.
  - Opcode constants, including `OP_LUI`, `OP_AUIPC`, `OP_JALR`.
- Sub-module `ctrl_decode`: purely combinational decoder producing `ctrl_t`, rs1/rs2 use flags, rd, and illegal.
- `ctrl_pipeline` instantiates `ctrl_decode` and owns the stage registers and hazard logic.

## Test plan
- lw x5,0(x1) (0x0000A283), then add x6,x5,x2 (0x00228333): `id_stall`=1 for one cycle; `ex_valid`=0 in the following cycle; the add reaches `wb` four cycles after the lw enters EX.
- lw x0,0(x1) (0x0000A003), then add x6,x0,x2 (0x00200333): no stall; `ex_ctrl.reg_wr_en`=0 for the load.
- bltu (0x00006063) gives `ex_ctrl.branch_op`=LTU. Funct3=010 (0x00002063) gives `id_illegal`=1 and a bubble. With `EN_FULL_BR`=0, bltu is illegal.
- lui x7,0x12345 (0x123453B7): `wb_sel`=11, `ex_rd`=7. With `EN_UPPER`=0, `id_illegal`=1.
- `mem_stall` held for 3 cycles with all stages valid: every `*_ctrl`/`*_rd` is unchanged; `ex_redirect` in the same cycles has no effect until release.
- `rst_n`=0 for one cycle while all stages are valid: all valids are 0 after the edge.
